// File: rtl/key_trigger_pkg.sv
// Shared constants, cycle-count helper and repeat-FSM state type for the panel key front-end.
package key_trigger_pkg;

    localparam int unsigned CLK_KHZ = 50_000;
    localparam int unsigned N_KEYS  = 4;

    // Key bit positions inside the {wat,run,mod,pwr} vectors
    localparam int unsigned K_PWR = 0;
    localparam int unsigned K_MOD = 1;
    localparam int unsigned K_RUN = 2;
    localparam int unsigned K_WAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DLY  = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_t;

    function automatic int unsigned c_ms(input int unsigned ms);
        return ms * CLK_KHZ;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus symmetric counter debounce for one raw key; rise pulses with the level.
module key_debounce
    import key_trigger_pkg::*;
#(
    parameter int unsigned DEB_CMAX = c_ms(20)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DEB_CMAX < 1) ? 1 : $clog2(DEB_CMAX + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // Counter only advances while the synced value disagrees with the debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            level  <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            rise   <= 1'b0;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CMAX)) begin
                level <= sync_q[1];
                rise  <= sync_q[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_trigger.sv
// Panel key front-end: debounces four keys, applies chord rejection and priority,
// and emits one-cycle trigger pulses with optional auto-repeat on the water key.
module key_trigger
    import key_trigger_pkg::*;
#(
    parameter int unsigned DEB_CMAX = c_ms(20),
    parameter bit          RPT_EN   = 1'b1,
    parameter int unsigned RPT_DLY  = c_ms(600),
    parameter int unsigned RPT_PER  = c_ms(200)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              k_pwr,
    input  logic              k_mod,
    input  logic              k_run,
    input  logic              k_wat,
    output logic              tr_pwr,
    output logic              tr_mod,
    output logic              tr_run,
    output logic              tr_wat,
    output logic [N_KEYS-1:0] held
);

    localparam int unsigned RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int unsigned RPT_W   = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(RPT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(RPT_PER - 1);

    logic [N_KEYS-1:0] raw_keys;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] rise;

    assign raw_keys = {k_wat, k_run, k_mod, k_pwr};
    assign held     = level;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_deb
        key_debounce #(
            .DEB_CMAX (DEB_CMAX)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_keys[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    rpt_state_t        state, state_nx;
    logic [RPT_W-1:0]  cnt, cnt_nx;
    logic [RPT_W-1:0]  cnt_last_c;
    logic [N_KEYS-1:0] stable_c;
    logic [N_KEYS-1:0] ev_c;
    logic [N_KEYS-1:0] trig_c;
    logic              others_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                            <= ST_IDLE;
            cnt                              <= '0;
            {tr_wat, tr_run, tr_mod, tr_pwr} <= '0;
        end else begin
            state                            <= state_nx;
            cnt                              <= cnt_nx;
            {tr_wat, tr_run, tr_mod, tr_pwr} <= trig_c;
        end
    end

    // Chord filter, fixed priority and the water-key repeat FSM
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        trig_c     = '0;
        ev_c       = '0;
        stable_c   = level & ~rise;
        others_c   = level[K_PWR] | level[K_MOD] | level[K_RUN];
        cnt_last_c = (state == ST_DLY) ? DLY_LAST : PER_LAST;

        // "Already pressed" excludes keys rising this cycle so same-cycle ties reach priority
        for (int i = 0; i < int'(N_KEYS); i++) begin
            ev_c[i] = rise[i] && ((stable_c & ~(N_KEYS'(1) << i)) == '0);
        end

        if (ev_c[K_PWR])      trig_c[K_PWR] = 1'b1;
        else if (ev_c[K_RUN]) trig_c[K_RUN] = 1'b1;
        else if (ev_c[K_MOD]) trig_c[K_MOD] = 1'b1;
        else if (ev_c[K_WAT]) trig_c[K_WAT] = 1'b1;

        case (state)
            ST_IDLE: begin
                if (RPT_EN && trig_c[K_WAT]) begin
                    state_nx = ST_DLY;
                    cnt_nx   = '0;
                end
            end
            ST_DLY, ST_RPT: begin
                if (!level[K_WAT] || others_c) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == cnt_last_c) begin
                    trig_c[K_WAT] = 1'b1;
                    state_nx      = ST_RPT;
                    cnt_nx        = '0;
                end else begin
                    cnt_nx = cnt + RPT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule
